// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline skid stage: occupancy states and default bubble.
package pipe_pkg;

  // Occupancy doubles as the state encoding; 2'd3 is unreachable and self-recovers.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2,
    OCC_BAD   = 2'd3
  } occ_t;

  localparam int unsigned DEFAULT_DATA_W = 32;

  // All-zero payload decodes as a nop in every stage.
  localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc and stick at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid
// buffer, flush, and saturating stall/flush performance counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W = 32,
  parameter logic [DATA_W-1:0]    BUBBLE = DATA_W'(DEFAULT_BUBBLE),
  parameter int unsigned          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  occ_t              state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;
  logic              stall_inc, flush_inc;

  // State and payload registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= OCC_EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Next state and payload moves; flush overrides any normal transfer.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      OCC_EMPTY: begin
        if (in_fire) begin
          state_nxt = OCC_ONE;
          main_nxt  = in_data;
        end
      end
      OCC_ONE: begin
        if (in_fire && out_fire) begin
          main_nxt = in_data;
        end else if (in_fire) begin
          state_nxt = OCC_TWO;
          skid_nxt  = in_data;
        end else if (out_fire) begin
          state_nxt = OCC_EMPTY;
          main_nxt  = BUBBLE;
        end
      end
      OCC_TWO: begin
        if (out_fire) begin
          state_nxt = OCC_ONE;
          main_nxt  = skid_q;
          skid_nxt  = BUBBLE;
        end
      end
      default: begin
        state_nxt = OCC_EMPTY;
        main_nxt  = BUBBLE;
        skid_nxt  = BUBBLE;
      end
    endcase
    if (flush) begin
      state_nxt = OCC_EMPTY;
      main_nxt  = BUBBLE;
      skid_nxt  = BUBBLE;
    end
  end

  // Handshake outputs and counter increments, all decoded from registered state.
  always_comb begin
    in_ready  = (state != OCC_TWO);
    out_valid = (state != OCC_EMPTY);
    out_data  = main_q;
    occupancy = state;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    // The illegal encoding recovers silently, so it must not bump either counter.
    stall_inc = out_valid && !out_ready && (state != OCC_BAD);
    flush_inc = flush && ((state == OCC_ONE) || (state == OCC_TWO));
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
Parametrised inter-stage pipeline register with a valid/ready handshake, a two-entry skid buffer, flush, and saturating stall/flush counters. It replaces fixed-field stage registers (D/E, E/M, M/W) that have only a clear input. Upstream stalls are driven by backpressure instead of global freeze logic, and full throughput is kept. Each payload is a concatenation of the stage fields (Instr, RS, RT, EXT, PC8, WBA, ...), packed by the instantiating stage.

Parameters:
DATA_W, 32, payload width in bits (≥1)
BUBBLE, {DATA_W{1'b0}}, payload value held by an invalid entry; all-zero decodes as nop
CNT_W, 16, width of each saturating performance counter (≥2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; highest priority
flush  input  1  discard all held entries this edge
in_valid  input  1  upstream payload valid
in_ready  output  1  stage can accept; registered, depends only on state
in_data  input  DATA_W  upstream payload
out_valid  output  1  main entry valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  main entry payload; BUBBLE when invalid
occupancy  output  2  0 EMPTY, 1 ONE, 2 TWO
stall_cnt  output  CNT_W  cycles with out_valid && !out_ready, saturating
flush_cnt  output  CNT_W  flushes that discarded ≥1 entry, saturating

Behaviour:
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Storage: main register (drives out_*) and skid register. in_ready = (state != TWO). out_valid = (state != EMPTY).
- Reset (sync): state=EMPTY; main=skid=BUBBLE; counters=0. Result: out_valid=0, in_ready=1, out_data=BUBBLE, occupancy=0.
- Priority per edge: reset > flush > normal transfer.
- Flush: state←EMPTY; main, skid ←BUBBLE. A concurrent in_fire is dropped and a concurrent out_fire still counts as consumed downstream. Next cycle in_ready=1.
- Normal transitions:
  - EMPTY: in_fire → ONE, main←in_data.
  - ONE: in_fire && out_fire → ONE, main←in_data. in_fire only → TWO, skid←in_data. out_fire only → EMPTY, main←BUBBLE. Neither → hold.
  - TWO: no in_fire is possible. out_fire → ONE, main←skid, skid←BUBBLE. Otherwise hold.
- Latency: 1 cycle from in_fire into EMPTY/ONE (after out_fire) to out_valid. Throughput is 1 per cycle when out_ready stays high.
- Ordering: strict FIFO, no duplication or loss except on flush or reset.
- Payload is stable while out_valid && !out_ready. Payload is never modified in place.
- stall_cnt: +1 on each edge where out_valid && !out_ready (sampled pre-edge, flush cycle included). Holds at 2^CNT_W−1.
- flush_cnt: +1 on flush edge when occupancy != 0. Holds at max.
- Reset mid-operation discards everything, including counters. There is no partial state.
- State encoding 2'd3 is illegal. It recovers to EMPTY on the next edge, same as flush, with no counter change.

Decomposition:
- Package pipe_pkg holds OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2, and the default BUBBLE constant.
- Sub-module sat_counter (params CNT_W; ports clk, reset, inc, count) is instantiated twice.
- State machine and datapath stay in pipe_skid_stage.

Test Plan:
1. Reset → out_valid=0, in_ready=1, out_data=0, occupancy=0, stall_cnt=flush_cnt=0. Same after reset asserted mid-TWO.
2. Stream 0x11,0x22,0x33 on consecutive cycles, out_ready=1 → out_data 0x11,0x22,0x33 on cycles 1,2,3. Occupancy stays 1. stall_cnt=0.
3. out_ready=0, send 0xA1 then 0xA2 → occupancy=2, in_ready=0, out_data=0xA1 held. After 3 blocked cycles stall_cnt=3. Raise out_ready → out 0xA1 then 0xA2, no loss.
4. In state TWO, assert flush with in_valid=1 (in_data=0xFF) → next cycle occupancy=0, out_data=0, in_ready=1, flush_cnt=1. 0xFF never appears.
5. Flush while EMPTY → flush_cnt unchanged (0).
6. CNT_W=2, hold out_valid && !out_ready 6 cycles → stall_cnt reads 1,2,3,3,3,3.
